// File: rtl/if_id_skid_reg_pkg.sv
// Shared types and constants for the IF/ID pipeline register.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package if_id_skid_reg_pkg;

   // Width of the instruction and PC fields.
   localparam int XLEN = 32;

   // Bubble presented to decode when no entry is held (addi x0,x0,0).
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   // PC presented to decode when no entry is held.
   localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

   // One fetched word together with the address it came from.
   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } if_id_t;

   // Occupancy is encoded directly as {main_v, skid_v}; 2'b01 cannot occur
   // because the skid entry is only ever filled behind a valid main entry.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b10,
      TWO   = 2'b11
   } skid_state_e;

endpackage

// File: rtl/if_id_skid_reg_slot.sv
// One valid+payload holding register used for both the main and skid entries.
// Latency: load/clear take effect on the next rising edge.
// Backpressure: none here; the parent decides when to load or clear.
module if_id_skid_reg_slot
   import if_id_skid_reg_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         load,
   input  logic                         clear,
   input  logic [$bits(if_id_t)-1:0]    d,
   output logic                         v,
   output logic [$bits(if_id_t)-1:0]    q
);

   // Valid bit: reset and clear dominate; a load marks the slot occupied.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v <= 1'b0;
      end else if (clear) begin
         v <= 1'b0;
      end else if (load) begin
         v <= 1'b1;
      end
   end

   // Payload only moves on capture; its content is ignored while v=0,
   // so it carries no reset.
   always_ff @(posedge clk) begin
      if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/if_id_skid_reg.sv
// IF->ID pipeline register with a 2-entry skid buffer and synchronous flush.
// Latency: 1 cycle from in_fire (empty) to out_valid; 1 word/cycle sustained.
// Backpressure: in_ready = ~skid_v, purely registered; no path from out_ready.
module if_id_skid_reg
   import if_id_skid_reg_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_instr,
   input  logic [XLEN-1:0]   in_pc,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_instr,
   output logic [XLEN-1:0]   out_pc
);

   logic        main_v;
   logic        skid_v;
   if_id_t      main_q;
   if_id_t      skid_q;
   if_id_t      in_word;
   if_id_t      main_d;

   logic        main_load;
   logic        main_clear;
   logic        skid_load;
   logic        skid_clear;

   logic        in_fire;
   logic        out_fire;

   skid_state_e state;
   skid_state_e state_nxt;

   assign in_word.instr = in_instr;
   assign in_word.pc    = in_pc;

   // The slot valid bits are the FSM state register.
   assign state     = skid_state_e'({main_v, skid_v});

   assign in_ready  = ~skid_v;
   assign out_valid = main_v;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   // Next state and slot enables; flush squashes everything, including a
   // word accepted from fetch in the same cycle.
   always_comb begin
      state_nxt  = state;
      main_load  = 1'b0;
      main_clear = 1'b0;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      main_d     = in_word;

      if (flush) begin
         state_nxt  = EMPTY;
         main_clear = 1'b1;
         skid_clear = 1'b1;
      end else begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  state_nxt = ONE;
                  main_load = 1'b1;
               end
            end
            ONE: begin
               if (out_fire && in_fire) begin
                  // Decode drains main while fetch refills it: pass-through.
                  state_nxt = ONE;
                  main_load = 1'b1;
               end else if (out_fire) begin
                  state_nxt  = EMPTY;
                  main_clear = 1'b1;
               end else if (in_fire) begin
                  // Decode stalled: park the younger word in the skid slot.
                  state_nxt = TWO;
                  skid_load = 1'b1;
               end
            end
            TWO: begin
               // in_ready is low here, so only the drain case exists.
               if (out_fire) begin
                  state_nxt  = ONE;
                  main_load  = 1'b1;
                  main_d     = skid_q;
                  skid_clear = 1'b1;
               end
            end
            default: begin
               // Unreachable encoding; fall back to empty rather than hang.
               state_nxt  = EMPTY;
               main_clear = 1'b1;
               skid_clear = 1'b1;
            end
         endcase
      end
   end

   if_id_skid_reg_slot u_main (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (main_load),
      .clear (main_clear),
      .d     (main_d),
      .v     (main_v),
      .q     (main_q)
   );

   if_id_skid_reg_slot u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (skid_load),
      .clear (skid_clear),
      .d     (in_word),
      .v     (skid_v),
      .q     (skid_q)
   );

   // Decode sees a NOP bubble at RESET_PC whenever nothing is held, so
   // the unreset payload never leaks out.
   always_comb begin
      out_instr = NOP_INSTR;
      out_pc    = RESET_PC;
      if (main_v) begin
         out_instr = main_q.instr;
         out_pc    = main_q.pc;
      end
   end

   // The skid entry is never valid without a main entry.
   a_no_skid_only: assert property (@(posedge clk) disable iff (!rst_n)
      !(!main_v && skid_v));

   // A stalled, unflushed output must hold its payload.
   a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready && !flush) |=> ($stable(out_instr) && $stable(out_pc)));

   // Fetch is only refused when the skid slot is occupied.
   a_ready_skid: assert property (@(posedge clk) disable iff (!rst_n)
      !in_ready |-> skid_v);

   // The slot valid bits track the computed next state.
   a_state_track: assert property (@(posedge clk)
      rst_n |=> (state == $past(state_nxt)));

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed and randomized self-checking bench for if_id_skid_reg.
// Latency: checks assume one-cycle capture into the main entry.
// Backpressure: exercises skid fill, drain, flush and reset.
module tb_if_id_skid_reg;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] RPC = 32'h0000_0000;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;

   int checks;
   int failures;

   if_id_skid_reg dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .in_pc     (in_pc),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_pc    (out_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Instruction pattern tied to its PC so ordering errors show up in both fields.
   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return 32'hA500_0000 | pc;
   endfunction

   task automatic present(input logic [31:0] pc);
      in_valid = 1'b1;
      in_pc    = pc;
      in_instr = instr_of(pc);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      in_instr = 32'h0; in_pc = 32'h0;
      tick(); tick();
      rst_n = 1'b1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_instr !== NOP) begin failures++; $display("FAIL reset_out_instr got=%h exp=%h", out_instr, NOP); end
      checks++; if (out_pc !== RPC) begin failures++; $display("FAIL reset_out_pc got=%h exp=%h", out_pc, RPC); end
   endtask

   task automatic test_single();
      out_ready = 1'b1;
      in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h0;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", out_valid); end
      checks++; if (out_instr !== 32'h0050_0093) begin failures++; $display("FAIL single_instr got=%h exp=00500093", out_instr); end
      checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL single_pc got=%h exp=0", out_pc); end
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drain_valid got=%b exp=0", out_valid); end
      checks++; if (out_instr !== NOP) begin failures++; $display("FAIL single_drain_instr got=%h exp=%h", out_instr, NOP); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      present(32'h0); tick();
      present(32'h4); tick();
      present(32'h8);
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%b exp=0", in_ready); end
      checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL bp_full_pc got=%h exp=0", out_pc); end
      tick();
      checks++; if (in_ready !== 1'b0 || out_pc !== 32'h0) begin failures++; $display("FAIL bp_hold rdy=%b pc=%h exp rdy=0 pc=0", in_ready, out_pc); end
      out_ready = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_instr !== instr_of(32'h4)) begin failures++; $display("FAIL bp_second v=%b pc=%h instr=%h exp pc=4", out_valid, out_pc, out_instr); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_reopen got=%b exp=1", in_ready); end
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h8 || out_instr !== instr_of(32'h8)) begin failures++; $display("FAIL bp_third v=%b pc=%h instr=%h exp pc=8", out_valid, out_pc, out_instr); end
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
   endtask

   task automatic test_streaming();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         present(32'(i * 4));
         tick();
         checks++; if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || in_ready !== 1'b1) begin
            failures++; $display("FAIL stream_%0d v=%b pc=%h rdy=%b exp v=1 pc=%h rdy=1", i, out_valid, out_pc, in_ready, 32'(i * 4));
         end
      end
      in_valid = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_end got=%b exp=0", out_valid); end
   endtask

   task automatic test_flush();
      // Flush while full, with a word offered that fetch cannot hand over.
      out_ready = 1'b0;
      present(32'h10); tick();
      present(32'h14); tick();
      present(32'h18); flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || out_instr !== NOP || out_pc !== RPC) begin failures++; $display("FAIL flush_two v=%b instr=%h pc=%h exp v=0 instr=%h", out_valid, out_instr, out_pc, NOP); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_two_ready got=%b exp=1", in_ready); end
      out_ready = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_two_leak got=%b pc=%h exp=0", out_valid, out_pc); end
      // Flush while holding one entry: the word accepted in that cycle is dropped too.
      out_ready = 1'b0;
      present(32'h1C); tick();
      present(32'h20); flush = 1'b1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_one_ready got=%b exp=1", in_ready); end
      tick();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      checks++; if (out_valid !== 1'b0 || out_instr !== NOP) begin failures++; $display("FAIL flush_one v=%b instr=%h exp v=0", out_valid, out_instr); end
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_one_leak got=%b pc=%h exp=0", out_valid, out_pc); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      present(32'h30); tick();
      present(32'h34); tick();
      in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++; if (out_valid !== 1'b0 || out_pc !== RPC || in_ready !== 1'b1) begin failures++; $display("FAIL rstmid v=%b pc=%h rdy=%b exp v=0 pc=0 rdy=1", out_valid, out_pc, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_leak got=%b pc=%h exp=0", out_valid, out_pc); end
      // Reset beats a simultaneous flush and a simultaneous fetch handshake.
      present(32'h40); flush = 1'b1; rst_n = 1'b0;
      tick();
      rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || out_instr !== NOP) begin failures++; $display("FAIL rst_wins v=%b instr=%h exp v=0", out_valid, out_instr); end
   endtask

   task automatic test_soak();
      logic [63:0] q[$];
      logic [31:0] seq;
      logic        m_in_fire;
      logic        m_out_fire;
      logic [63:0] head;
      seq = 32'h0;
      q.delete();
      for (int c = 0; c < 10000; c++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         flush     = ($urandom_range(0, 99) < 4);
         in_pc     = seq << 2;
         in_instr  = $urandom;
         checks++;
         if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
            failures++; $display("FAIL soak_ctrl c=%0d v=%b rdy=%b exp v=%b rdy=%b", c, out_valid, in_ready, q.size() > 0, q.size() < 2);
         end
         head = (q.size() > 0) ? q[0] : {NOP, RPC};
         checks++;
         if ({out_instr, out_pc} !== head) begin
            failures++; $display("FAIL soak_data c=%0d got=%h_%h exp=%h_%h", c, out_instr, out_pc, head[63:32], head[31:0]);
         end
         m_in_fire  = in_valid && (q.size() < 2);
         m_out_fire = out_ready && (q.size() > 0);
         tick();
         if (m_in_fire) seq = seq + 1;
         if (flush) begin
            q.delete();
         end else begin
            if (m_out_fire) void'(q.pop_front());
            if (m_in_fire) q.push_back({in_instr, in_pc});
         end
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = 32'h0;
      in_pc     = 32'h0;
      flush     = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_single();
      test_backpressure();
      test_streaming();
      test_flush();
      test_reset_mid();
      test_soak();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
